// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the six-digit clock display scanner.
//   SEG_BLANK / SEG_DASH : active-low segment patterns {g,f,e,d,c,b,a}
//   SEG_ROM              : BCD 0..9 to active-low segment patterns
//   mode_e               : run / set-field selector from the counter group
//   DIG_*                : scan slot index of each display digit
//   snap_t               : per-frame snapshot of digits and mode
package clock_disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    // Entry n is the pattern for digit n.
    localparam logic [9:0][SEG_W-1:0] SEG_ROM = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_SET_S = 2'd1,
        MODE_SET_M = 2'd2,
        MODE_SET_H = 2'd3
    } mode_e;

    localparam logic [IDX_W-1:0] DIG_MSB_H = 3'd0;
    localparam logic [IDX_W-1:0] DIG_LSB_H = 3'd1;
    localparam logic [IDX_W-1:0] DIG_MSB_M = 3'd2;
    localparam logic [IDX_W-1:0] DIG_LSB_M = 3'd3;
    localparam logic [IDX_W-1:0] DIG_MSB_S = 3'd4;
    localparam logic [IDX_W-1:0] DIG_LSB_S = 3'd5;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;  // [0]=msb_h .. [5]=lsb_s
        mode_e                              mode;
    } snap_t;

endpackage

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
//   bcd      : 4-bit digit value
//   seg_n_c  : active-low segments {g,f,e,d,c,b,a}; non-BCD values show a dash
import clock_disp_pkg::*;

module bcd_to_seg7 (
    input  logic [DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]   seg_n_c
);

    always_comb begin
        seg_n_c = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg_n_c = SEG_ROM[bcd];
        end
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed common-anode display driver for the clock.
//   clk100khz        : system clock
//   rst              : asynchronous active-high reset
//   msb_h .. lsb_s   : BCD time digits from the counter group
//   mode_flag        : 0 run, 1 set seconds, 2 set minutes, 3 set hours
//   dig_n            : active-low one-hot digit enable, bit0 = msb_h
//   seg_n            : active-low segments {g,f,e,d,c,b,a}
//   dp_n             : active-low colon dots
import clock_disp_pkg::*;

module clock_display_scan #(
    parameter int unsigned SCAN_DIV  = 100,
    parameter int unsigned BLINK_DIV = 25000
) (
    input  logic                  clk100khz,
    input  logic                  rst,
    input  logic [DIGIT_W-1:0]    msb_h,
    input  logic [DIGIT_W-1:0]    lsb_h,
    input  logic [DIGIT_W-1:0]    msb_m,
    input  logic [DIGIT_W-1:0]    lsb_m,
    input  logic [DIGIT_W-1:0]    msb_s,
    input  logic [DIGIT_W-1:0]    lsb_s,
    input  logic [1:0]            mode_flag,
    output logic [NUM_DIGITS-1:0] dig_n,
    output logic [SEG_W-1:0]      seg_n,
    output logic                  dp_n
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLINK_W-1:0]    blink_cnt;
    logic                  blink_on;
    snap_t                 snap;

    logic [DIGIT_W-1:0]    cur_digit_c;
    logic [SEG_W-1:0]      dec_seg_n_c;
    logic                  field_sel_c;
    logic [NUM_DIGITS-1:0] dig_n_c;
    logic [SEG_W-1:0]      seg_n_c;
    logic                  dp_n_c;

    // Slot timer and digit index.
    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= DIG_MSB_H;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == DIG_LSB_S) ? DIG_MSB_H : IDX_W'(idx + 3'd1);
        end else begin
            scan_cnt <= SCAN_W'(scan_cnt + 1'b1);
        end
    end

    // Free-running blink phase, independent of the scan.
    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= BLINK_W'(blink_cnt + 1'b1);
        end
    end

    // Frame-coherent snapshot so a counter carry never tears the display.
    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (idx == DIG_MSB_H && scan_cnt == '0) begin
            snap.digits <= {lsb_s, msb_s, lsb_m, msb_m, lsb_h, msb_h};
            snap.mode   <= mode_e'(mode_flag);
        end
    end

    assign cur_digit_c = snap.digits[idx];

    bcd_to_seg7 u_dec (
        .bcd     (cur_digit_c),
        .seg_n_c (dec_seg_n_c)
    );

    // Output pattern for the current slot; scan_cnt==0 is the anti-ghost blank.
    always_comb begin
        field_sel_c = 1'b0;
        case (snap.mode)
            MODE_SET_S: field_sel_c = (idx == DIG_MSB_S) || (idx == DIG_LSB_S);
            MODE_SET_M: field_sel_c = (idx == DIG_MSB_M) || (idx == DIG_LSB_M);
            MODE_SET_H: field_sel_c = (idx == DIG_MSB_H) || (idx == DIG_LSB_H);
            default:    field_sel_c = 1'b0;
        endcase

        dig_n_c = ~(NUM_DIGITS'(1) << idx);
        if (scan_cnt == '0) begin
            dig_n_c = '1;
        end

        seg_n_c = dec_seg_n_c;
        if (field_sel_c && !blink_on) begin
            seg_n_c = SEG_BLANK;
        end

        // Colon sits after the hours and minutes pairs; steady while setting.
        dp_n_c = 1'b1;
        if ((idx == DIG_LSB_H || idx == DIG_LSB_M) &&
            (snap.mode != MODE_RUN || blink_on)) begin
            dp_n_c = 1'b0;
        end
    end

    always_ff @(posedge clk100khz or posedge rst) begin
        if (rst) begin
            dig_n <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            dig_n <= dig_n_c;
            seg_n <= seg_n_c;
            dp_n  <= dp_n_c;
        end
    end

endmodule
